tmr_fault_scheduler: RTL

Campaign controller for the triple-replicated core array. It sequences fault-injection events into one selected replica, or rotates across replicas, at a programmable interval. After each injection it watches the three replica counters for disagreement and keeps injection and detected-mismatch statistics. It sits between the test host/bench and the replica array, replacing the shared injection enable with per-replica enables.

---
 rtl/tmr_fault_scheduler.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/tmr_fault_scheduler.sv
// Fault-injection campaign controller for a triple-replicated core array.
// Issues per-replica injection pulses at a programmable interval and counts observed replica disagreement.
module tmr_fault_scheduler #(
    parameter int W  = 8,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [IW-1:0] interval,
    input  logic [7:0]    num_faults,
    input  logic [1:0]    target_sel,
    input  logic [W-1:0]  inj_pattern,
    input  logic [W-1:0]  c0,
    input  logic [W-1:0]  c1,
    input  logic [W-1:0]  c2,
    output logic [W-1:0]  inj_data,
    output logic [2:0]    inj_en,
    output logic          busy,
    output logic          done,
    output logic [7:0]    fault_count,
    output logic [7:0]    mismatch_count,
    output logic          mismatch,
    output logic [1:0]    last_target
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_INJECT = 3'd2,
        ST_OBS1   = 3'd3,
        ST_OBS2   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [IW-1:0] timer_r;
    logic [IW-1:0] interval_r;
    logic [7:0]    num_faults_r;
    logic [1:0]    target_sel_r;
    logic [W-1:0]  pattern_r;
    logic [1:0]    rot_r;
    logic          seen_r;
    logic [7:0]    fault_count_r;
    logic [7:0]    mismatch_count_r;
    logic          mismatch_r;
    logic [1:0]    last_target_r;
    logic [W-1:0]  inj_data_r;
    logic [2:0]    inj_en_r;
    logic          busy_r;
    logic          done_r;
    logic          disagree_s;
    logic [1:0]    tgt_s;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] v;
        case (idx)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Replica comparison and injection target selection.
    always_comb begin
        disagree_s = (c0 != c1) || (c1 != c2);
        if (target_sel_r == 2'd3) begin
            tgt_s = rot_r;
        end else begin
            tgt_s = target_sel_r;
        end
    end

    // Campaign sequencing; stop overrides everything outside IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (num_faults == 8'd0) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    next_state_s = ST_IDLE;
                end else if (timer_r == {IW{1'b0}}) begin
                    next_state_s = ST_INJECT;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_INJECT: begin
                if (stop) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_OBS1;
                end
            end
            ST_OBS1: begin
                if (stop) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_OBS2;
                end
            end
            ST_OBS2: begin
                if (stop) begin
                    next_state_s = ST_IDLE;
                end else if (fault_count_r == num_faults_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath, statistics and registered outputs (decoded from the upcoming state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r          <= {IW{1'b0}};
            interval_r       <= {IW{1'b0}};
            num_faults_r     <= 8'd0;
            target_sel_r     <= 2'd0;
            pattern_r        <= {W{1'b0}};
            rot_r            <= 2'd0;
            seen_r           <= 1'b0;
            fault_count_r    <= 8'd0;
            mismatch_count_r <= 8'd0;
            mismatch_r       <= 1'b0;
            last_target_r    <= 2'd0;
            inj_data_r       <= {W{1'b0}};
            inj_en_r         <= 3'b000;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            mismatch_r <= disagree_s;
            busy_r     <= (next_state_s != ST_IDLE);
            done_r     <= (next_state_s == ST_DONE);
            if (next_state_s == ST_INJECT) begin
                inj_en_r   <= onehot3(tgt_s);
                inj_data_r <= pattern_r;
            end else begin
                inj_en_r   <= 3'b000;
                inj_data_r <= {W{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    if (next_state_s != ST_IDLE) begin
                        interval_r       <= interval;
                        num_faults_r     <= num_faults;
                        target_sel_r     <= target_sel;
                        pattern_r        <= inj_pattern;
                        fault_count_r    <= 8'd0;
                        mismatch_count_r <= 8'd0;
                        timer_r          <= interval;
                        rot_r            <= 2'd0;
                        seen_r           <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Count down to zero only, so the largest interval cannot wrap.
                    if (next_state_s == ST_WAIT) begin
                        timer_r <= timer_r - {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                ST_INJECT: begin
                    if (next_state_s == ST_OBS1) begin
                        fault_count_r <= fault_count_r + 8'd1;
                        last_target_r <= tgt_s;
                        if (target_sel_r == 2'd3) begin
                            rot_r <= (rot_r == 2'd2) ? 2'd0 : rot_r + 2'd1;
                        end
                    end
                end
                ST_OBS1: begin
                    seen_r <= seen_r | disagree_s;
                end
                ST_OBS2: begin
                    seen_r <= 1'b0;
                    if ((next_state_s != ST_IDLE) && (seen_r || disagree_s)
                        && (mismatch_count_r != 8'hFF)) begin
                        mismatch_count_r <= mismatch_count_r + 8'd1;
                    end
                    if (next_state_s == ST_WAIT) begin
                        timer_r <= interval_r;
                    end
                end
                default: begin
                    seen_r <= seen_r;
                end
            endcase
        end
    end

    assign inj_data       = inj_data_r;
    assign inj_en         = inj_en_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign fault_count    = fault_count_r;
    assign mismatch_count = mismatch_count_r;
    assign mismatch       = mismatch_r;
    assign last_target    = last_target_r;

endmodule
